// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: receive-side checker for a heartbeat source that should
// pulse once every 2^N cycles. Measures each inter-beat interval, locks after
// a run of good beats, flags early beats and missed beats, and declares the
// source lost after too many consecutive misses.
module heartbeat_monitor #(
    parameter int N          = 8,   // expected period is 2^N cycles
    parameter int TOL        = 2,   // accepted deviation from the period, in cycles
    parameter int LOCK_COUNT = 4,   // consecutive good intervals needed to lock
    parameter int MISS_LIMIT = 2    // consecutive misses that declare the source lost
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in,
    output logic         alive,
    output logic         lost,
    output logic         early,
    output logic         late,
    output logic [N+1:0] period,
    output logic [15:0]  beats
);

    // Interval counter is two bits wider than the period so that it can hold
    // P+TOL and still has headroom to saturate while the source is lost.
    localparam int CW = N + 2;
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam int P  = 1 << N;

    localparam logic [CW-1:0] CNT_LO      = CW'(P - TOL);
    localparam logic [CW-1:0] CNT_HI      = CW'(P + TOL);
    // After a timeout the count restarts as if a beat had arrived exactly at
    // P, so the next expected beat is still measured against the ideal grid.
    localparam logic [CW-1:0] CNT_ANCHOR  = CW'(TOL + 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
    localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_COUNT);
    localparam logic [MW-1:0] MISS_TARGET = MW'(MISS_LIMIT);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } state_t;

    state_t          state_q,    state_d;
    logic            in_d_q;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [GW-1:0]   good_cnt_q, good_cnt_d;
    logic [MW-1:0]   miss_cnt_q, miss_cnt_d;
    logic [CW-1:0]   period_q,   period_d;
    logic [15:0]     beats_q,    beats_d;
    logic            early_q,    early_d;
    logic            late_q,     late_d;
    logic            alive_q,    alive_d;
    logic            lost_q,     lost_d;

    logic            edge_w;
    logic            timeout_w;
    logic            in_window_w;
    logic [GW-1:0]   good_inc_w;
    logic [MW-1:0]   miss_inc_w;
    logic [CW-1:0]   cnt_inc_w;

    // Only rising edges of the heartbeat count; a level held high is one beat.
    assign edge_w      = in & ~in_d_q;
    // A miss is declared when the window closes without a beat; an edge
    // arriving in that same cycle takes priority and is treated as good.
    assign timeout_w   = ~edge_w && (cnt_q == CNT_HI);
    // The counter never exceeds CNT_HI while tracking, so only the lower
    // bound needs testing to tell a good beat from an early one.
    assign in_window_w = (cnt_q >= CNT_LO);
    assign good_inc_w  = good_cnt_q + GW'(1);
    assign miss_inc_w  = miss_cnt_q + MW'(1);
    assign cnt_inc_w   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Next-state, counter and output decisions for each monitor state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc_w;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        period_d   = period_q;
        beats_d    = beats_q;
        early_d    = 1'b0;
        late_d     = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                if (edge_w) begin
                    // First beat only starts the measurement.
                    state_d = ST_TRACK;
                    cnt_d   = CNT_ONE;
                end else if (timeout_w) begin
                    late_d     = 1'b1;
                    cnt_d      = CNT_ANCHOR;
                    miss_cnt_d = miss_inc_w;
                    if (miss_inc_w >= MISS_TARGET) begin
                        state_d = ST_LOST;
                    end
                end
            end

            ST_TRACK, ST_LOCKED: begin
                if (edge_w) begin
                    cnt_d    = CNT_ONE;
                    period_d = cnt_q;
                    if (in_window_w) begin
                        beats_d    = beats_q + 16'd1;
                        miss_cnt_d = '0;
                        if (state_q == ST_TRACK) begin
                            good_cnt_d = good_inc_w;
                            if (good_inc_w >= GOOD_TARGET) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end else begin
                        // An early beat breaks the run of good intervals.
                        early_d    = 1'b1;
                        good_cnt_d = '0;
                        state_d    = ST_TRACK;
                    end
                end else if (timeout_w) begin
                    late_d     = 1'b1;
                    cnt_d      = CNT_ANCHOR;
                    miss_cnt_d = miss_inc_w;
                    if (state_q == ST_TRACK) begin
                        good_cnt_d = '0;
                    end
                    if (miss_inc_w >= MISS_TARGET) begin
                        state_d = ST_LOST;
                    end
                end
            end

            ST_LOST: begin
                // Timeouts are ignored here and the counter simply saturates;
                // any beat restarts tracking from scratch.
                if (edge_w) begin
                    state_d    = ST_TRACK;
                    cnt_d      = CNT_ONE;
                    good_cnt_d = '0;
                    miss_cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_SEARCH;
            end
        endcase

        alive_d = (state_d == ST_LOCKED);
        lost_d  = (state_d == ST_LOST);
    end

    // State, edge-detect and interval counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SEARCH;
            in_d_q     <= 1'b0;
            cnt_q      <= '0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            in_d_q     <= in;
            cnt_q      <= cnt_d;
            good_cnt_q <= good_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Registered outputs, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= '0;
            beats_q  <= '0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            alive_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            beats_q  <= beats_d;
            early_q  <= early_d;
            late_q   <= late_d;
            alive_q  <= alive_d;
            lost_q   <= lost_d;
        end
    end

    assign alive  = alive_q;
    assign lost   = lost_q;
    assign early  = early_q;
    assign late   = late_q;
    assign period = period_q;
    assign beats  = beats_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Testbench for heartbeat_monitor (N=4, TOL=1, LOCK_COUNT=3, MISS_LIMIT=2).
// A timestamp-based reference model predicts every output each cycle; key
// points of each scenario are also checked against fixed expected values.
module tb_heartbeat_monitor;

    localparam int N          = 4;
    localparam int P          = 16;
    localparam int TOL        = 1;
    localparam int LOCK_COUNT = 3;
    localparam int MISS_LIMIT = 2;

    localparam int M_SEARCH = 0;
    localparam int M_TRACK  = 1;
    localparam int M_LOCKED = 2;
    localparam int M_LOST   = 3;

    logic        clk;
    logic        reset;
    logic        in_s;
    logic        alive;
    logic        lost;
    logic        early;
    logic        late;
    logic [5:0]  period;
    logic [15:0] beats;

    int checks;
    int errors;

    // Reference model state: mode, time of the last (real or virtual) beat.
    int          m_mode;
    int          m_step;
    int          anchor;
    int          goods;
    int          misses;
    logic        m_in_prev;
    logic        m_alive;
    logic        m_lost;
    logic        m_early;
    logic        m_late;
    logic [5:0]  m_period;
    logic [15:0] m_beats;

    wire [25:0] obs_w = {alive, lost, early, late, period, beats};
    wire [25:0] exp_w = {m_alive, m_lost, m_early, m_late, m_period, m_beats};

    heartbeat_monitor #(
        .N(N), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT), .MISS_LIMIT(MISS_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .in(in_s),
        .alive(alive), .lost(lost), .early(early), .late(late),
        .period(period), .beats(beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode    = M_SEARCH;
        m_step    = 0;
        anchor    = 0;
        goods     = 0;
        misses    = 0;
        m_in_prev = 1'b0;
        m_alive   = 1'b0;
        m_lost    = 1'b0;
        m_early   = 1'b0;
        m_late    = 1'b0;
        m_period  = '0;
        m_beats   = '0;
    endtask

    // One clock of the reference model; gap is the time since the last beat.
    task automatic model_step(input logic v);
        int   gap;
        logic rise;
        rise      = v & ~m_in_prev;
        m_in_prev = v;
        gap       = m_step - anchor;
        m_early   = 1'b0;
        m_late    = 1'b0;
        if (m_mode == M_LOST) begin
            if (rise) begin
                m_mode = M_TRACK; anchor = m_step; goods = 0; misses = 0;
            end
        end else if (rise) begin
            if (m_mode == M_SEARCH) begin
                m_mode = M_TRACK; anchor = m_step;
            end else begin
                m_period = 6'(gap);
                anchor   = m_step;
                if (gap >= P - TOL) begin
                    m_beats = m_beats + 16'd1;
                    misses  = 0;
                    if (m_mode == M_TRACK) begin
                        goods++;
                        if (goods >= LOCK_COUNT) m_mode = M_LOCKED;
                    end
                end else begin
                    m_early = 1'b1; goods = 0; m_mode = M_TRACK;
                end
            end
        end else if (gap == P + TOL) begin
            // Missed beat: assume a virtual beat landed exactly at P.
            m_late = 1'b1;
            anchor = anchor + P;
            misses++;
            if (m_mode == M_TRACK) goods = 0;
            if (misses >= MISS_LIMIT) m_mode = M_LOST;
        end
        m_step++;
        m_alive = (m_mode == M_LOCKED);
        m_lost  = (m_mode == M_LOST);
    endtask

    // Drive one cycle of input from a negedge and return at the next negedge.
    task automatic drive_cycle(input logic v);
        in_s = v;
        @(posedge clk);
        model_step(v);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs_w !== 26'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", obs_w);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0);
            checks++;
            if (obs_w !== exp_w) begin
                errors++;
                $display("FAIL reset_idle step=%0d got=%h exp=%h", m_step - 1, obs_w, exp_w);
            end
        end
    endtask

    task automatic test_lock();
        int w;
        w = int'($urandom_range(1, 3));
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < P; k++) begin
                drive_cycle(k < w);
                checks++;
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("FAIL lock_model step=%0d got=%h exp=%h", m_step - 1, obs_w, exp_w);
                end
                checks++;
                if ({early, late} !== 2'b00) begin
                    errors++;
                    $display("FAIL lock_no_pulse early=%0b late=%0b exp 0 0", early, late);
                end
                if (b == 2 && k == 0) begin
                    checks++;
                    if (alive !== 1'b0) begin
                        errors++;
                        $display("FAIL lock_too_soon alive=%0b exp 0", alive);
                    end
                end
                if (b == 3 && k == 0) begin
                    checks++;
                    if ({alive, lost, period, beats} !== {1'b1, 1'b0, 6'd16, 16'd3}) begin
                        errors++;
                        $display("FAIL lock_reached alive=%0b lost=%0b period=%0d beats=%0d exp 1 0 16 3",
                                 alive, lost, period, beats);
                    end
                end
                if (k == 0) $display("beat lock b=%0d period=%0d beats=%0d alive=%0b", b, period, beats, alive);
            end
        end
    endtask

    task automatic test_early();
        int ivs[5] = '{12, 16, 16, 16, 16};
        int w;
        w = int'($urandom_range(1, 3));
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < ivs[i]; k++) begin
                drive_cycle(k < w);
                checks++;
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("FAIL early_model step=%0d got=%h exp=%h", m_step - 1, obs_w, exp_w);
                end
                if (i == 1 && k == 0) begin
                    checks++;
                    if ({early, alive, period} !== {1'b1, 1'b0, 6'd12}) begin
                        errors++;
                        $display("FAIL early_pulse early=%0b alive=%0b period=%0d exp 1 0 12", early, alive, period);
                    end
                end
                if (i == 1 && k == 1) begin
                    checks++;
                    if (early !== 1'b0) begin
                        errors++;
                        $display("FAIL early_width early=%0b exp 0", early);
                    end
                end
                if (i == 4 && k == 0) begin
                    checks++;
                    if (alive !== 1'b1) begin
                        errors++;
                        $display("FAIL early_relock alive=%0b exp 1", alive);
                    end
                end
                if (k == 0) $display("beat early i=%0d period=%0d beats=%0d alive=%0b", i, period, beats, alive);
            end
        end
    endtask

    task automatic test_miss();
        int ivs[4] = '{32, 16, 32, 16};
        int w;
        w = int'($urandom_range(1, 3));
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < ivs[i]; k++) begin
                drive_cycle(k < w);
                checks++;
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("FAIL miss_model step=%0d got=%h exp=%h", m_step - 1, obs_w, exp_w);
                end
                if (ivs[i] == 32 && k == 16) begin
                    checks++;
                    if (late !== 1'b0) begin
                        errors++;
                        $display("FAIL miss_late_early late=%0b exp 0", late);
                    end
                end
                if (ivs[i] == 32 && k == 17) begin
                    // The second omission only stays locked if the good beat cleared the miss count.
                    checks++;
                    if ({late, alive, lost} !== 3'b110) begin
                        errors++;
                        $display("FAIL miss_late late=%0b alive=%0b lost=%0b exp 1 1 0", late, alive, lost);
                    end
                end
                if (i > 0 && k == 0) begin
                    checks++;
                    if ({period, alive, early} !== {6'd16, 1'b1, 1'b0}) begin
                        errors++;
                        $display("FAIL miss_resync period=%0d alive=%0b early=%0b exp 16 1 0", period, alive, early);
                    end
                end
                if (k == 0) $display("beat miss i=%0d period=%0d beats=%0d alive=%0b", i, period, beats, alive);
            end
        end
    endtask

    task automatic test_lost();
        int ivs[5];
        int w;
        w = int'($urandom_range(1, 3));
        ivs = '{int'($urandom_range(40, 80)), 16, 16, 16, 16};
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < ivs[i]; k++) begin
                drive_cycle(k < w);
                checks++;
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("FAIL lost_model step=%0d got=%h exp=%h", m_step - 1, obs_w, exp_w);
                end
                if (i == 0 && k == 17) begin
                    checks++;
                    if ({late, alive, lost} !== 3'b110) begin
                        errors++;
                        $display("FAIL lost_first_late late=%0b alive=%0b lost=%0b exp 1 1 0", late, alive, lost);
                    end
                end
                // Second timeout lands 17 cycles after the virtual beat at +16.
                if (i == 0 && k == 33) begin
                    checks++;
                    if ({late, alive, lost} !== 3'b101) begin
                        errors++;
                        $display("FAIL lost_second_late late=%0b alive=%0b lost=%0b exp 1 0 1", late, alive, lost);
                    end
                end
                if (i == 0 && k == ivs[0] - 1) begin
                    checks++;
                    if ({late, lost} !== 2'b01) begin
                        errors++;
                        $display("FAIL lost_hold late=%0b lost=%0b exp 0 1", late, lost);
                    end
                end
                if (i == 1 && k == 0) begin
                    checks++;
                    if ({lost, alive} !== 2'b00) begin
                        errors++;
                        $display("FAIL lost_exit lost=%0b alive=%0b exp 0 0", lost, alive);
                    end
                end
                if ((i == 3 || i == 4) && k == 0) begin
                    checks++;
                    if (alive !== (i == 4)) begin
                        errors++;
                        $display("FAIL lost_relock i=%0d alive=%0b exp %0b", i, alive, (i == 4));
                    end
                end
                if (k == 0) $display("beat lost i=%0d period=%0d beats=%0d lost=%0b", i, period, beats, lost);
            end
        end
    endtask

    task automatic test_boundary();
        int ivs[7] = '{17, 15, 18, 16, 16, 16, 16};
        int w;
        w = int'($urandom_range(1, 3));
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < ivs[i]; k++) begin
                drive_cycle(k < w);
                checks++;
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("FAIL bound_model step=%0d got=%h exp=%h", m_step - 1, obs_w, exp_w);
                end
                if ((i == 1 || i == 2) && k == 0) begin
                    checks++;
                    if ({period, early, alive} !== {(i == 1) ? 6'd17 : 6'd15, 1'b0, 1'b1}) begin
                        errors++;
                        $display("FAIL bound_good i=%0d period=%0d early=%0b alive=%0b", i, period, early, alive);
                    end
                end
                if (i == 2 && k == 17) begin
                    checks++;
                    if (late !== 1'b1) begin
                        errors++;
                        $display("FAIL bound_late late=%0b exp 1", late);
                    end
                end
                if (i == 3 && k == 0) begin
                    checks++;
                    if ({early, late, period, alive} !== {1'b1, 1'b0, 6'd2, 1'b0}) begin
                        errors++;
                        $display("FAIL bound_early early=%0b late=%0b period=%0d alive=%0b exp 1 0 2 0",
                                 early, late, period, alive);
                    end
                end
                if (i == 6 && k == 0) begin
                    checks++;
                    if (alive !== 1'b1) begin
                        errors++;
                        $display("FAIL bound_relock alive=%0b exp 1", alive);
                    end
                end
                if (k == 0) $display("beat bound i=%0d period=%0d beats=%0d alive=%0b", i, period, beats, alive);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        w = int'($urandom_range(1, 3));
        checks++;
        if (alive !== 1'b1) begin
            errors++;
            $display("FAIL rmid_locked alive=%0b exp 1", alive);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({alive, lost, early, late, period, beats} !== 26'd0) begin
            errors++;
            $display("FAIL rmid_async alive=%0b period=%0d beats=%0d exp 0 0 0", alive, period, beats);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 40; k++) begin
            drive_cycle(1'b1);
            checks++;
            if (obs_w !== exp_w) begin
                errors++;
                $display("FAIL rmid_held step=%0d got=%h exp=%h", m_step - 1, obs_w, exp_w);
            end
            checks++;
            if ({beats, early} !== 17'd0) begin
                errors++;
                $display("FAIL rmid_one_edge beats=%0d early=%0b exp 0 0", beats, early);
            end
        end
        checks++;
        if (lost !== 1'b1) begin
            errors++;
            $display("FAIL rmid_lost lost=%0b exp 1", lost);
        end
        drive_cycle(1'b0);
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < P; k++) begin
                drive_cycle(k < w);
                checks++;
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("FAIL rmid_model step=%0d got=%h exp=%h", m_step - 1, obs_w, exp_w);
                end
                if (i == 3 && k == 0) begin
                    checks++;
                    if ({alive, beats} !== {1'b1, 16'd3}) begin
                        errors++;
                        $display("FAIL rmid_relock alive=%0b beats=%0d exp 1 3", alive, beats);
                    end
                end
                if (k == 0) $display("beat rmid i=%0d period=%0d beats=%0d alive=%0b", i, period, beats, alive);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int sel;
            int iv;
            int w;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       iv = int'($urandom_range(15, 17));
            else if (sel < 7)  iv = int'($urandom_range(8, 14));
            else if (sel < 9)  iv = int'($urandom_range(18, 36));
            else               iv = int'($urandom_range(40, 70));
            w = int'($urandom_range(1, 3));
            for (int k = 0; k < iv; k++) begin
                drive_cycle(k < w);
                checks++;
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("FAIL random_model step=%0d got=%h exp=%h", m_step - 1, obs_w, exp_w);
                end
                checks++;
                if ((early & late) | (alive & lost)) begin
                    errors++;
                    $display("FAIL random_exclusive early=%0b late=%0b alive=%0b lost=%0b", early, late, alive, lost);
                end
            end
            $display("beat random i=%0d iv=%0d period=%0d beats=%0d alive=%0b lost=%0b",
                     i, iv, period, beats, alive, lost);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        in_s   = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        test_reset();
        test_lock();
        test_early();
        test_miss();
        test_lost();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
